// File: rtl/xbar_master_port.sv
// Master-port stage of the stream crossbar: locks onto the arbiter-granted slave for a whole packet and buffers its beats.
// Optional build macro XBAR_SKID_BUFFER_EN selects a 2-entry skid buffer instead of the 1-entry output register.
module xbar_master_port #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3,
    parameter int PORT_IDX     = 0,
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_in,
    input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]  s_data_i,
    input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
    input  logic [S_DATA_COUNT-1:0]                    s_last_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
    input  logic [T_ID___WIDTH-1:0]                    grant_i,
    input  logic                                       grant_valid_i,
    output logic [S_DATA_COUNT-1:0]                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                    m_data_o,
    output logic                                       m_valid_o,
    output logic                                       m_last_o,
    output logic [T_ID___WIDTH-1:0]                    m_id_o,
    input  logic                                       m_ready_i,
    output logic                                       busy_o
);

    typedef enum logic {IDLE, LOCK} state_e;

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic                    last;
        logic [T_ID___WIDTH-1:0] id;
    } beat_t;

    state_e                  state_q, state_d;
    logic [T_ID___WIDTH-1:0] sel_q, sel_d;
    logic                    grant_ok;
    logic                    can_accept;
    logic                    push;
    logic                    pop;
    beat_t                   in_beat;
    beat_t                   head_q, head_d;

    // Grant qualification: range, slave valid and destination are all checked in the same cycle.
    always_comb begin
        grant_ok = 1'b0;
        if (grant_valid_i && (32'(grant_i) < 32'(S_DATA_COUNT))) begin
            grant_ok = s_valid_i[grant_i] && (s_dest_i[grant_i] == T_DEST_WIDTH'(PORT_IDX));
        end
    end

    assign push    = (state_q == LOCK) && s_valid_i[sel_q] && can_accept;
    assign pop     = m_valid_o && m_ready_i;
    assign in_beat = '{data: s_data_i[sel_q], last: s_last_i[sel_q], id: sel_q};

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    state_d = LOCK;
                    sel_d   = grant_i;
                end
            end
            LOCK: begin
                if (push && s_last_i[sel_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < S_DATA_COUNT; gi++) begin : g_ready
            assign s_ready_o[gi] = (state_q == LOCK) && (sel_q == T_ID___WIDTH'(gi)) && can_accept;
        end
    endgenerate

`ifdef XBAR_SKID_BUFFER_EN
    beat_t      tail_q, tail_d;
    logic [1:0] count_q, count_d;

    // Ready depends on occupancy alone, cutting the m_ready_i -> s_ready_o path.
    assign can_accept = (count_q != 2'd2);
    assign m_valid_o  = (count_q != 2'd0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = in_beat;
                end else begin
                    tail_d = in_beat;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Push needs count < 2 and pop needs count > 0, so count is 1 here.
                head_d = in_beat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
`else
    logic valid_q, valid_d;

    // A full register may still accept when the head leaves in the same cycle.
    assign can_accept = !valid_q || m_ready_i;
    assign m_valid_o  = valid_q;

    always_comb begin
        head_d  = head_q;
        valid_d = valid_q;
        if (push) begin
            head_d  = in_beat;
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end
`endif

    assign m_data_o = head_q.data;
    assign m_last_o = head_q.last;
    assign m_id_o   = head_q.id;
    assign busy_o   = (state_q == LOCK);

endmodule

// File: tb/tb_xbar_master_port.sv
// Directed bench for xbar_master_port (PORT_IDX=1): reset, packet, dest filter, backpressure, lock, back-to-back.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time unit later.
module tb_xbar_master_port;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][7:0] s_data;
    logic [1:0]      s_valid;
    logic [1:0]      s_last;
    logic [1:0][1:0] s_dest;
    logic            grant;
    logic            grant_valid;
    logic [1:0]      s_ready;
    logic [7:0]      m_data;
    logic            m_valid;
    logic            m_last;
    logic            m_id;
    logic            m_ready;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    xbar_master_port #(
        .T_DATA_WIDTH(8),
        .S_DATA_COUNT(2),
        .M_DATA_COUNT(3),
        .PORT_IDX    (1)
    ) dut (
        .clk_i        (clk),
        .rst_in       (rst_n),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_last_i     (s_last),
        .s_dest_i     (s_dest),
        .grant_i      (grant),
        .grant_valid_i(grant_valid),
        .s_ready_o    (s_ready),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_last_o     (m_last),
        .m_id_o       (m_id),
        .m_ready_i    (m_ready),
        .busy_o       (busy)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        s_data      = '0;
        s_valid     = '0;
        s_last      = '0;
        s_dest      = '0;
        grant       = 1'b0;
        grant_valid = 1'b0;
        m_ready     = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        #2;
        n_cmp++; if (s_ready !== 2'b00) begin n_bad++; $display("FAIL reset s_ready got %b exp 00", s_ready); end
        n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset m_data got %h exp 00", m_data); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset m_valid got %b exp 0", m_valid); end
        n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset m_last got %b exp 0", m_last); end
        n_cmp++; if (m_id !== 1'b0) begin n_bad++; $display("FAIL reset m_id got %b exp 0", m_id); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy got %b exp 0", busy); end
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        $display("reset: released, busy=%b m_valid=%b", busy, m_valid);
    endtask

    task automatic test_basic;
        logic exp_busy, exp_mv;
        int   idx;
        for (int c = 0; c <= 6; c++) begin
            idle_inputs();
            s_dest[1]   = 2'd1;
            m_ready     = 1'b1;
            grant       = 1'b1;
            grant_valid = (c == 0);
            idx         = (c == 0) ? 0 : c - 1;
            s_valid[1]  = (c <= 4);
            s_data[1]   = 8'(8'hA0 + idx);
            s_last[1]   = (c == 4);
            #1;
            exp_busy = (c >= 1) && (c <= 4);
            exp_mv   = (c >= 2) && (c <= 5);
            n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL basic busy c%0d got %b exp %b", c, busy, exp_busy); end
            n_cmp++; if (s_ready !== {exp_busy, 1'b0}) begin n_bad++; $display("FAIL basic s_ready c%0d got %b exp %b0", c, s_ready, exp_busy); end
            n_cmp++; if (m_valid !== exp_mv) begin n_bad++; $display("FAIL basic m_valid c%0d got %b exp %b", c, m_valid, exp_mv); end
            if (exp_mv) begin
                n_cmp++; if (m_data !== 8'(8'hA0 + c - 2)) begin n_bad++; $display("FAIL basic m_data c%0d got %h exp %h", c, m_data, 8'(8'hA0 + c - 2)); end
                n_cmp++; if (m_last !== (c == 5)) begin n_bad++; $display("FAIL basic m_last c%0d got %b exp %b", c, m_last, (c == 5)); end
                n_cmp++; if (m_id !== 1'b1) begin n_bad++; $display("FAIL basic m_id c%0d got %b exp 1", c, m_id); end
                $display("basic: out data=%h last=%b id=%b", m_data, m_last, m_id);
            end
            cyc();
        end
    endtask

    task automatic test_dest_mismatch;
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            grant_valid = 1'b1;
            grant       = 1'b0;
            s_valid[0]  = 1'b1;
            s_data[0]   = 8'h55;
            s_dest[0]   = 2'd2;
            m_ready     = 1'b1;
            #1;
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dest busy c%0d got %b exp 0", c, busy); end
            n_cmp++; if (s_ready !== 2'b00) begin n_bad++; $display("FAIL dest s_ready c%0d got %b exp 00", c, s_ready); end
            n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL dest m_valid c%0d got %b exp 0", c, m_valid); end
            cyc();
        end
        $display("dest: grant to slave 0 with dest 2 ignored");
    endtask

    task automatic test_backpressure;
        int         next_in, n_out, held;
        logic       locked_m, exp_rdy, prev_stall, acc, pop;
        logic [7:0] pd;
        logic       pl, pid;
        next_in = 0; n_out = 0; held = 0;
        locked_m = 1'b0; prev_stall = 1'b0; pd = 8'h00; pl = 1'b0; pid = 1'b0;
        for (int c = 0; c < 60 && n_out < 6; c++) begin
            idle_inputs();
            s_dest[0]   = 2'd1;
            grant_valid = (c == 0);
            m_ready     = (c % 3 == 0);
            s_valid[0]  = (next_in < 6);
            s_data[0]   = 8'(8'hB0 + next_in);
            s_last[0]   = (next_in == 5);
            #1;
            if (prev_stall) begin
                n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp hold m_valid c%0d got %b exp 1", c, m_valid); end
                n_cmp++; if (m_data !== pd) begin n_bad++; $display("FAIL bp hold m_data c%0d got %h exp %h", c, m_data, pd); end
                n_cmp++; if (m_last !== pl) begin n_bad++; $display("FAIL bp hold m_last c%0d got %b exp %b", c, m_last, pl); end
                n_cmp++; if (m_id !== pid) begin n_bad++; $display("FAIL bp hold m_id c%0d got %b exp %b", c, m_id, pid); end
            end
`ifdef XBAR_SKID_BUFFER_EN
            exp_rdy = locked_m && (held < 2);
`else
            exp_rdy = locked_m && ((held == 0) || m_ready);
`endif
            n_cmp++; if (s_ready !== {1'b0, exp_rdy}) begin n_bad++; $display("FAIL bp s_ready c%0d got %b exp 0%b", c, s_ready, exp_rdy); end
            n_cmp++; if (busy !== locked_m) begin n_bad++; $display("FAIL bp busy c%0d got %b exp %b", c, busy, locked_m); end
            n_cmp++; if (m_valid !== (held != 0)) begin n_bad++; $display("FAIL bp m_valid c%0d got %b exp %b", c, m_valid, (held != 0)); end
            pop = m_valid && m_ready;
            if (pop) begin
                n_cmp++; if (m_data !== 8'(8'hB0 + n_out)) begin n_bad++; $display("FAIL bp m_data beat%0d got %h exp %h", n_out, m_data, 8'(8'hB0 + n_out)); end
                n_cmp++; if (m_last !== (n_out == 5)) begin n_bad++; $display("FAIL bp m_last beat%0d got %b exp %b", n_out, m_last, (n_out == 5)); end
                n_cmp++; if (m_id !== 1'b0) begin n_bad++; $display("FAIL bp m_id beat%0d got %b exp 0", n_out, m_id); end
                $display("bp: out beat %0d data=%h last=%b", n_out, m_data, m_last);
                n_out++;
            end
            acc = s_ready[0] && s_valid[0];
            if (acc) begin
                if (s_last[0]) locked_m = 1'b0;
                next_in++;
            end
            if (c == 0) locked_m = 1'b1;
            held       = held + (acc ? 1 : 0) - (pop ? 1 : 0);
            prev_stall = m_valid && !m_ready;
            pd         = m_data;
            pl         = m_last;
            pid        = m_id;
            cyc();
        end
        n_cmp++; if (n_out != 6) begin n_bad++; $display("FAIL bp beat count got %0d exp 6", n_out); end
    endtask

    task automatic test_lock_exclusive;
        logic       eb  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0] er  [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        logic       emv [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] emd [8] = '{8'h00, 8'h00, 8'hD0, 8'hD1, 8'hD2, 8'h00, 8'hE0, 8'hE1};
        logic       eml [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       eid [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            s_dest      = {2'd1, 2'd1};
            m_ready     = 1'b1;
            grant_valid = (c <= 5);
            grant       = (c != 0);
            s_valid[0]  = (c <= 3);
            s_data[0]   = (c <= 1) ? 8'hD0 : ((c == 2) ? 8'hD1 : 8'hD2);
            s_last[0]   = (c == 3);
            s_valid[1]  = (c >= 1) && (c <= 6);
            s_data[1]   = (c <= 5) ? 8'hE0 : 8'hE1;
            s_last[1]   = (c == 6);
            #1;
            n_cmp++; if (busy !== eb[c]) begin n_bad++; $display("FAIL lock busy c%0d got %b exp %b", c, busy, eb[c]); end
            n_cmp++; if (s_ready !== er[c]) begin n_bad++; $display("FAIL lock s_ready c%0d got %b exp %b", c, s_ready, er[c]); end
            n_cmp++; if (m_valid !== emv[c]) begin n_bad++; $display("FAIL lock m_valid c%0d got %b exp %b", c, m_valid, emv[c]); end
            if (emv[c]) begin
                n_cmp++; if (m_data !== emd[c]) begin n_bad++; $display("FAIL lock m_data c%0d got %h exp %h", c, m_data, emd[c]); end
                n_cmp++; if (m_last !== eml[c]) begin n_bad++; $display("FAIL lock m_last c%0d got %b exp %b", c, m_last, eml[c]); end
                n_cmp++; if (m_id !== eid[c]) begin n_bad++; $display("FAIL lock m_id c%0d got %b exp %b", c, m_id, eid[c]); end
                $display("lock: out data=%h last=%b id=%b", m_data, m_last, m_id);
            end
            cyc();
        end
    endtask

    task automatic test_back_to_back;
        logic       eb  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0] er  [7] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        logic       emv [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] emd [7] = '{8'h00, 8'h00, 8'hF0, 8'hF0, 8'hC0, 8'hC1, 8'h00};
        logic       eml [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 7; c++) begin
            idle_inputs();
            s_dest[0]   = 2'd1;
            m_ready     = (c >= 3);
            grant_valid = (c <= 2);
            grant       = 1'b0;
            s_valid[0]  = (c <= 4);
            s_data[0]   = (c <= 1) ? 8'hF0 : ((c <= 3) ? 8'hC0 : 8'hC1);
            s_last[0]   = (c <= 1) || (c == 4);
            #1;
            n_cmp++; if (busy !== eb[c]) begin n_bad++; $display("FAIL b2b busy c%0d got %b exp %b", c, busy, eb[c]); end
            n_cmp++; if (s_ready !== er[c]) begin n_bad++; $display("FAIL b2b s_ready c%0d got %b exp %b", c, s_ready, er[c]); end
            n_cmp++; if (m_valid !== emv[c]) begin n_bad++; $display("FAIL b2b m_valid c%0d got %b exp %b", c, m_valid, emv[c]); end
            if (emv[c]) begin
                n_cmp++; if (m_data !== emd[c]) begin n_bad++; $display("FAIL b2b m_data c%0d got %h exp %h", c, m_data, emd[c]); end
                n_cmp++; if (m_last !== eml[c]) begin n_bad++; $display("FAIL b2b m_last c%0d got %b exp %b", c, m_last, eml[c]); end
                n_cmp++; if (m_id !== 1'b0) begin n_bad++; $display("FAIL b2b m_id c%0d got %b exp 0", c, m_id); end
                $display("b2b: out data=%h last=%b ready=%b", m_data, m_last, m_ready);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid_packet;
        int n_acc;
        n_acc = 0;
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            s_dest[0]   = 2'd1;
            grant_valid = (c == 0);
            s_valid[0]  = 1'b1;
            s_data[0]   = 8'(8'h70 + n_acc);
            #1;
            if (s_ready[0]) n_acc++;
            if (c < 3) cyc();
        end
        n_cmp++; if (s_ready !== 2'b00) begin n_bad++; $display("FAIL rstmid full s_ready got %b exp 00", s_ready); end
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid full m_valid got %b exp 1", m_valid); end
        n_cmp++; if (m_data !== 8'h70) begin n_bad++; $display("FAIL rstmid full m_data got %h exp 70", m_data); end
`ifdef XBAR_SKID_BUFFER_EN
        n_cmp++; if (n_acc != 2) begin n_bad++; $display("FAIL rstmid held beats got %0d exp 2", n_acc); end
`else
        n_cmp++; if (n_acc != 1) begin n_bad++; $display("FAIL rstmid held beats got %0d exp 1", n_acc); end
`endif
        rst_n = 1'b0;
        #1;
        n_cmp++; if (s_ready !== 2'b00) begin n_bad++; $display("FAIL rstmid s_ready got %b exp 00", s_ready); end
        n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL rstmid m_data got %h exp 00", m_data); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid m_valid got %b exp 0", m_valid); end
        n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rstmid m_last got %b exp 0", m_last); end
        n_cmp++; if (m_id !== 1'b0) begin n_bad++; $display("FAIL rstmid m_id got %b exp 0", m_id); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid busy got %b exp 0", busy); end
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            s_dest[0]  = 2'd1;
            s_valid[0] = 1'b1;
            s_data[0]  = 8'(8'h70 + n_acc);
            m_ready    = 1'b1;
            #1;
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid after busy c%0d got %b exp 0", c, busy); end
            n_cmp++; if (s_ready !== 2'b00) begin n_bad++; $display("FAIL rstmid after s_ready c%0d got %b exp 00", c, s_ready); end
            n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid after m_valid c%0d got %b exp 0", c, m_valid); end
            cyc();
        end
        $display("rstmid: %0d buffered beats discarded by reset", n_acc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dest_mismatch();
        test_backpressure();
        test_lock_exclusive();
        test_back_to_back();
        test_reset_mid_packet();
        idle_inputs();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
